dma_cmd_splitter: RTL and testbench
===================================

// Module: dma_cmd_splitter
// PURPOSE
//  Consumes a transfer descriptor (address, byte count, start pulse) from the AXI-Lite command
//  register block. Splits it into AXI burst commands for the ACP master datapath.
//  Bursts never exceed MAX_BEATS and never cross a 4 KB boundary.
//  Counts completion responses and reports busy/done/err back to the register block.
// PARAMETERS
//  ADDR_WIDTH  32  byte-address width of cfg_addr/cmd_addr
//  DATA_BYTES  8   bytes per data beat (power of 2, 4..16)
//  MAX_BEATS   16  max beats per burst (power of 2, <=16, ACP/AXI3 limit)
//  LEN_WIDTH   24  width of cfg_bytes
// PORTS
//  ACLK       in   1           clock, all logic on rising edge
//  ARESETN    in   1           asynchronous active-low reset
//  start      in   1           1-cycle pulse: launch transfer using cfg_* sampled this cycle
//  cfg_addr   in   ADDR_WIDTH  transfer start byte address
//  cfg_bytes  in   LEN_WIDTH   transfer length in bytes
//  busy       out  1           transfer in progress (start accepted, done/err not yet pulsed)
//  done       out  1           1-cycle pulse: all bursts issued and all responses received
//  err        out  1           1-cycle pulse with done, or alone on a rejected start
//  cmd_valid  out  1           burst command valid
//  cmd_ready  in   1           downstream accepts command
//  cmd_addr   out  ADDR_WIDTH  burst start address
//  cmd_len    out  4           AXI length field = beats-1
//  cmd_last   out  1           final burst of this transfer
//  rsp_valid  in   1           one burst completed (always accepted, no ready)
//  rsp_err    in   1           completion carried SLVERR/DECERR; qualified by rsp_valid
// BEHAVIOUR
//  Reset: busy=0, done=0, err=0, cmd_valid=0, cmd_addr=0, cmd_len=0, cmd_last=0.
//   All counters clear and FSM returns to IDLE.
//   Reset mid-transfer abandons the transfer; no done or err pulse follows.
//  FSM states: IDLE, ISSUE, WAIT_RSP.
//  IDLE: on start, validate first.
//   Reject if cfg_bytes==0, cfg_addr%DATA_BYTES!=0, or cfg_bytes%DATA_BYTES!=0.
//   Rejected: err=1 for exactly the next cycle, done stays 0, busy stays 0, no command issued.
//   Accepted: next cycle busy=1, state ISSUE, cmd_valid=1 with the first burst (latency 1).
//   rem_beats = cfg_bytes/DATA_BYTES.
//  Burst size: beats = min(rem_beats, MAX_BEATS, (4096-addr[11:0])/DATA_BYTES).
//   Outputs cmd_len=beats-1. cmd_last=1 iff beats==rem_beats.
//  ISSUE: cmd_addr/cmd_len/cmd_last held stable while cmd_valid && !cmd_ready.
//   On handshake: addr += beats*DATA_BYTES, rem_beats -= beats, outstanding += 1.
//   If not last, next burst is presented the following cycle with cmd_valid kept high
//   (back-to-back accepts allowed: one command per cycle).
//   If last, cmd_valid=0 next cycle and state goes to WAIT_RSP.
//  Outstanding counter: 16 bits. +1 on cmd handshake, -1 on rsp_valid.
//   Both in the same cycle leave it unchanged.
//   rsp_valid while outstanding==0 is ignored.
//   Responses are counted in both ISSUE and WAIT_RSP.
//  rsp_err: sets sticky err_flag. Cleared when a new start is accepted.
//  WAIT_RSP: when outstanding reaches 0 (including via an rsp_valid this cycle):
//   next cycle done=1, err=err_flag, busy=0, state IDLE.
//  start while busy=1 is ignored; cfg_* changes while busy have no effect.
//  Address arithmetic is modulo 2^ADDR_WIDTH. 4K split uses addr[11:0] only.
// TESTING (DATA_BYTES=8, MAX_BEATS=16)
//  1. start, addr=0x1000, bytes=256, ready=1
//     -> cmds (0x1000,len15,last0), (0x1080,len15,last1) on consecutive cycles.
//     2 rsp -> done=1, err=0.
//  2. addr=0x1FC0, bytes=128 -> (0x1FC0,len7,last0), (0x2000,len7,last1); no 4K crossing.
//  3. bytes=0, or addr=0x1004 -> err=1 for one cycle at start+1.
//     busy=0, cmd_valid never asserted.
//  4. addr=0x0, bytes=24, cmd_ready low 10 cycles -> cmd_valid=1, cmd_addr=0, cmd_len=2
//     stable throughout. A start pulsed mid-stall is ignored.
//  5. 3-burst transfer, 2nd rsp has rsp_err=1 -> done=1 with err=1 after 3rd rsp.
//     Next start clears the flag: clean run gives err=0.
//  6. ARESETN low while ISSUE with outstanding=1 -> cmd_valid=0, busy=0 immediately (async).
//     No done after release. New start works normally.

Source files
------------

// File: rtl/dma_cmd_splitter.sv
// Splits a DMA transfer descriptor into AXI burst commands (<= MAX_BEATS, no 4 KB crossing)
// and tracks completions to report busy/done/err back to the register block.
module dma_cmd_splitter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_BYTES = 8,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned LEN_WIDTH  = 24
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [3:0]            cmd_len,
  output logic                  cmd_last,
  input  logic                  rsp_valid,
  input  logic                  rsp_err
);

  localparam int unsigned OFF_W   = $clog2(DATA_BYTES);
  localparam int unsigned BEAT_W  = $clog2(MAX_BEATS) + 1;
  localparam int unsigned CMP_W   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam int unsigned OUTS_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] rem_beats;
  logic [BEAT_W-1:0]    cur_beats;
  logic [OUTS_W-1:0]    outstanding;
  logic                 err_flag;

  // Beats for a burst starting at a_lo with rem beats left: min(rem, MAX_BEATS, beats to 4K edge).
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [11:0] a_lo,
                                                    input logic [LEN_WIDTH-1:0] rem);
    logic [CMP_W-1:0] win;
    logic [CMP_W-1:0] b;
    win = CMP_W'((13'h1000 - {1'b0, a_lo}) >> OFF_W);
    b   = CMP_W'(rem);
    if (b > CMP_W'(MAX_BEATS)) b = CMP_W'(MAX_BEATS);
    if (win < b) b = win;
    return BEAT_W'(b);
  endfunction

  logic                  hs;
  logic                  rsp_cnt;
  logic                  cfg_bad;
  logic                  err_seen;
  logic [LEN_WIDTH-1:0]  cfg_beats;
  logic [BEAT_W-1:0]     first_beats;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]  next_rem;
  logic [BEAT_W-1:0]     follow_beats;

  assign hs           = cmd_valid & cmd_ready;
  assign rsp_cnt      = rsp_valid & (outstanding != '0);
  assign cfg_bad      = (cfg_bytes == '0) | (|cfg_addr[OFF_W-1:0]) | (|cfg_bytes[OFF_W-1:0]);
  assign err_seen     = err_flag | (rsp_cnt & rsp_err);
  assign cfg_beats    = cfg_bytes >> OFF_W;
  assign first_beats  = burst_beats(cfg_addr[11:0], cfg_beats);
  assign next_addr    = cmd_addr + (ADDR_WIDTH'(cur_beats) << OFF_W);
  assign next_rem     = rem_beats - LEN_WIDTH'(cur_beats);
  assign follow_beats = burst_beats(next_addr[11:0], next_rem);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      rem_beats   <= '0;
      cur_beats   <= '0;
      outstanding <= '0;
      err_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      cmd_last    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;

      // Simultaneous issue and completion cancel out.
      if (hs && !rsp_cnt) begin
        outstanding <= outstanding + OUTS_W'(1);
      end else if (!hs && rsp_cnt) begin
        outstanding <= outstanding - OUTS_W'(1);
      end

      if (rsp_cnt && rsp_err) err_flag <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              state     <= ISSUE;
              busy      <= 1'b1;
              err_flag  <= 1'b0;
              cmd_valid <= 1'b1;
              cmd_addr  <= cfg_addr;
              rem_beats <= cfg_beats;
              cur_beats <= first_beats;
              cmd_len   <= 4'(first_beats - BEAT_W'(1));
              cmd_last  <= (LEN_WIDTH'(first_beats) == cfg_beats);
            end
          end
        end

        ISSUE: begin
          if (hs) begin
            rem_beats <= next_rem;
            if (cmd_last) begin
              cmd_valid <= 1'b0;
              state     <= WAIT_RSP;
            end else begin
              cmd_addr  <= next_addr;
              cur_beats <= follow_beats;
              cmd_len   <= 4'(follow_beats - BEAT_W'(1));
              cmd_last  <= (LEN_WIDTH'(follow_beats) == next_rem);
            end
          end
        end

        WAIT_RSP: begin
          // A response arriving this cycle can retire the last outstanding burst.
          if ((outstanding == '0) || ((outstanding == OUTS_W'(1)) && rsp_cnt)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= err_seen;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_splitter.sv
// Directed bench for dma_cmd_splitter: a burst-list model checks every presented command,
// and directed sequences check busy/done/err timing.
module tb_dma_cmd_splitter;

  logic        ACLK;
  logic        ARESETN;
  logic        start;
  logic [31:0] cfg_addr;
  logic [23:0] cfg_bytes;
  logic        busy;
  logic        done;
  logic        err;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        cmd_last;
  logic        rsp_valid;
  logic        rsp_err;

  dma_cmd_splitter #(
    .ADDR_WIDTH(32),
    .DATA_BYTES(8),
    .MAX_BEATS (16),
    .LEN_WIDTH (24)
  ) dut (
    .ACLK     (ACLK),
    .ARESETN  (ARESETN),
    .start    (start),
    .cfg_addr (cfg_addr),
    .cfg_bytes(cfg_bytes),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .cmd_last (cmd_last),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic        last;
  } burst_t;

  burst_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cfg_rejected(input logic [31:0] a, input int unsigned bytes);
    return (bytes == 0) || (a % 8 != 0) || (bytes % 8 != 0);
  endfunction

  // Expected burst list: greedy split by remaining beats, 16-beat cap and 4 KB page edge.
  task automatic model_push(input logic [31:0] a, input int unsigned bytes, output int n);
    int unsigned rem;
    int unsigned page_left;
    int unsigned beats;
    burst_t b;
    n = 0;
    if (cfg_rejected(a, bytes)) return;
    rem = bytes / 8;
    while (rem > 0) begin
      page_left = (4096 - (a % 4096)) / 8;
      beats = rem;
      if (beats > 16) beats = 16;
      if (beats > page_left) beats = page_left;
      b.addr = a;
      b.len  = 4'(beats - 1);
      b.last = (beats == rem);
      exp_q.push_back(b);
      a   = a + 32'(beats * 8);
      rem = rem - beats;
      n++;
    end
  endtask

  // Every presented command must match the head of the expected list.
  always @(negedge ACLK) begin
    if (ARESETN && cmd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cmd_unexpected: got cmd addr=0x%0h len=%0d last=%0b, expected no command (t=%0t)",
                 cmd_addr, cmd_len, cmd_last, $time);
      end else begin
        check("cmd_addr", 64'(cmd_addr), 64'(exp_q[0].addr));
        check("cmd_len", 64'(cmd_len), 64'(exp_q[0].len));
        check("cmd_last", 64'(cmd_last), 64'(exp_q[0].last));
        if (cmd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_start(input logic [31:0] a, input int unsigned bytes, output int n);
    model_push(a, bytes, n);
    start     = 1'b1;
    cfg_addr  = a;
    cfg_bytes = 24'(bytes);
    tick();
    start     = 1'b0;
    cfg_addr  = 32'hDEAD_BEE0;
    cfg_bytes = 24'h0000_40;
  endtask

  task automatic send_rsp(input logic e);
    rsp_valid = 1'b1;
    rsp_err   = e;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check("drain_cmds", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input logic exp_err);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 100) begin
      @(negedge ACLK);
      if (done) seen = 1;
      k++;
    end
    check("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("done_err", 64'(err), 64'(exp_err));
      check("done_busy", 64'(busy), 64'd0);
      @(negedge ACLK);
      check("done_pulse", 64'(done), 64'd0);
    end
    tick();
  endtask

  task automatic run_transfer(input logic [31:0] a, input int unsigned bytes);
    int n;
    do_start(a, bytes, n);
    check("busy_after_start", 64'(busy), 64'd1);
    wait_drain();
    for (int i = 0; i < n; i++) send_rsp(1'b0);
    wait_done(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESETN   = 1'b0;
    start     = 1'b0;
    cfg_addr  = '0;
    cfg_bytes = '0;
    cmd_ready = 1'b1;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    #22;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
    check("rst_cmd_len", 64'(cmd_len), 64'd0);
    check("rst_cmd_last", 64'(cmd_last), 64'd0);
    ARESETN = 1'b1;
    tick();

    // 1: two full bursts back to back
    do_start(32'h1000, 256, n);
    check("t1_nbursts", 64'(n), 64'd2);
    check("t1_model_addr1", 64'(exp_q[1].addr), 64'h1080);
    check("t1_model_last1", 64'(exp_q[1].last), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_valid0", 64'(cmd_valid), 64'd1);
    check("t1_addr0", 64'(cmd_addr), 64'h1000);
    tick();
    check("t1_addr1", 64'(cmd_addr), 64'h1080);
    check("t1_last1", 64'(cmd_last), 64'd1);
    tick();
    check("t1_valid_off", 64'(cmd_valid), 64'd0);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    send_rsp(1'b0);
    check("t1_busy_mid", 64'(busy), 64'd1);
    send_rsp(1'b0);
    wait_done(1'b0);

    // 2: 4 KB page edge splits the transfer
    do_start(32'h1FC0, 128, n);
    check("t2_nbursts", 64'(n), 64'd2);
    check("t2_model_len0", 64'(exp_q[0].len), 64'd7);
    check("t2_model_addr1", 64'(exp_q[1].addr), 64'h2000);
    check("t2_model_len1", 64'(exp_q[1].len), 64'd7);
    wait_drain();
    send_rsp(1'b0);
    send_rsp(1'b0);
    wait_done(1'b0);

    // 3: rejected descriptors
    do_start(32'h1000, 0, n);
    check("t3a_err", 64'(err), 64'd1);
    check("t3a_busy", 64'(busy), 64'd0);
    check("t3a_done", 64'(done), 64'd0);
    check("t3a_valid", 64'(cmd_valid), 64'd0);
    tick();
    check("t3a_err_pulse", 64'(err), 64'd0);
    do_start(32'h1004, 64, n);
    check("t3b_err", 64'(err), 64'd1);
    check("t3b_busy", 64'(busy), 64'd0);
    tick();
    check("t3b_err_pulse", 64'(err), 64'd0);
    do_start(32'h2000, 12, n);
    check("t3c_err", 64'(err), 64'd1);
    tick();
    check("t3c_valid", 64'(cmd_valid), 64'd0);

    // 4: stalled command held stable; a start mid-stall is ignored
    cmd_ready = 1'b0;
    do_start(32'h0, 24, n);
    check("t4_nbursts", 64'(n), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("t4_valid", 64'(cmd_valid), 64'd1);
      check("t4_addr", 64'(cmd_addr), 64'h0);
      check("t4_len", 64'(cmd_len), 64'd2);
      if (i == 5) begin
        start     = 1'b1;
        cfg_addr  = 32'h300;
        cfg_bytes = 24'd64;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start     = 1'b0;
    cmd_ready = 1'b1;
    wait_drain();
    send_rsp(1'b0);
    wait_done(1'b0);
    check("t4_idle_valid", 64'(cmd_valid), 64'd0);

    // 5: error on middle response is reported at done, then cleared
    do_start(32'h0, 384, n);
    check("t5_nbursts", 64'(n), 64'd3);
    wait_drain();
    send_rsp(1'b0);
    send_rsp(1'b1);
    check("t5_busy_mid", 64'(busy), 64'd1);
    check("t5_done_mid", 64'(done), 64'd0);
    send_rsp(1'b0);
    wait_done(1'b1);
    run_transfer(32'h4000, 128);

    // 6: async reset mid-issue with one burst outstanding
    do_start(32'h0, 384, n);
    tick();
    cmd_ready = 1'b0;
    tick();
    check("t6_valid_pre", 64'(cmd_valid), 64'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_valid_rst", 64'(cmd_valid), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    exp_q.delete();
    cmd_ready = 1'b1;
    tick();
    ARESETN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_no_done", 64'(done), 64'd0);
      check("t6_no_err", 64'(err), 64'd0);
    end
    run_transfer(32'h8000, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
